// File: rtl/sc_bi_decoder.sv
// Bipolar stochastic bitstream decoder: counts ones over a window of iLen accepted bits
// and reports the count plus the bipolar value 2*ones - len.
module sc_bi_decoder #(
    parameter int unsigned DATAWD = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              iStart,
    input  logic [DATAWD-1:0] iLen,
    input  logic              iBit,
    input  logic              iBitValid,
    input  logic              iReady,
    output logic              oBusy,
    output logic              oValid,
    output logic [DATAWD-1:0] oOnes,
    output logic [DATAWD:0]   oBipolar,
    output logic              oOverrun
);

    typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

    localparam logic [DATAWD-1:0] One = DATAWD'(1);

    state_e            state_q, state_d;
    logic [DATAWD-1:0] len_q, len_d;
    logic [DATAWD-1:0] ones_q, ones_d;
    logic [DATAWD-1:0] cnt_q, cnt_d;
    logic [DATAWD-1:0] res_ones_q, res_ones_d;
    logic [DATAWD:0]   res_bip_q, res_bip_d;
    logic              overrun_q, overrun_d;

    logic [DATAWD-1:0] ones_inc;
    logic [DATAWD-1:0] cnt_inc;
    logic [DATAWD:0]   bip_calc;

    assign ones_inc = ones_q + {{(DATAWD-1){1'b0}}, iBit};
    assign cnt_inc  = cnt_q + One;
    // Window never exceeds 2^DATAWD-1 bits, so the DATAWD+1 difference cannot overflow.
    assign bip_calc = {ones_inc, 1'b0} - {1'b0, len_q};

    always_comb begin
        state_d    = state_q;
        len_d      = len_q;
        ones_d     = ones_q;
        cnt_d      = cnt_q;
        res_ones_d = res_ones_q;
        res_bip_d  = res_bip_q;
        overrun_d  = overrun_q;

        if (iStart) begin
            len_d  = iLen;
            ones_d = '0;
            cnt_d  = '0;
            // Only a pending result that nobody acknowledged counts as lost.
            if (state_q == StDone && !iReady) begin
                overrun_d = 1'b1;
            end
            if (iLen == '0) begin
                state_d    = StDone;
                res_ones_d = '0;
                res_bip_d  = '0;
            end else begin
                state_d = StRun;
            end
        end else begin
            case (state_q)
                StIdle: ;
                StRun: begin
                    if (iBitValid) begin
                        cnt_d  = cnt_inc;
                        ones_d = ones_inc;
                        if (cnt_inc == len_q) begin
                            state_d    = StDone;
                            res_ones_d = ones_inc;
                            res_bip_d  = bip_calc;
                        end
                    end
                end
                StDone: begin
                    if (iReady) begin
                        state_d = StIdle;
                    end
                end
                default: state_d = StIdle;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= StIdle;
            len_q      <= '0;
            ones_q     <= '0;
            cnt_q      <= '0;
            res_ones_q <= '0;
            res_bip_q  <= '0;
            overrun_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            len_q      <= len_d;
            ones_q     <= ones_d;
            cnt_q      <= cnt_d;
            res_ones_q <= res_ones_d;
            res_bip_q  <= res_bip_d;
            overrun_q  <= overrun_d;
        end
    end

    assign oBusy    = (state_q == StRun);
    assign oValid   = (state_q == StDone);
    assign oOnes    = res_ones_q;
    assign oBipolar = res_bip_q;
    assign oOverrun = overrun_q;

endmodule

// File: tb/tb_sc_bi_decoder.sv
// Directed bench for sc_bi_decoder: table of decode windows plus hand-written
// sequences for overrun, abort and asynchronous reset.
module tb_sc_bi_decoder;

    logic       clk;
    logic       rst_n;
    logic       iStart;
    logic [7:0] iLen;
    logic       iBit;
    logic       iBitValid;
    logic       iReady;
    logic       oBusy;
    logic       oValid;
    logic [7:0] oOnes;
    logic [8:0] oBipolar;
    logic       oOverrun;

    int errors = 0;
    int checks = 0;

    sc_bi_decoder #(.DATAWD(8)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .iStart   (iStart),
        .iLen     (iLen),
        .iBit     (iBit),
        .iBitValid(iBitValid),
        .iReady   (iReady),
        .oBusy    (oBusy),
        .oValid   (oValid),
        .oOnes    (oOnes),
        .oBipolar (oBipolar),
        .oOverrun (oOverrun)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int           len;
        logic [255:0] bits;
        bit           gaps;
        int           exp_ones;
        int           exp_bip;
    } vec_t;

    vec_t vecs[6];

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic start_win(input int len, input logic ack);
        iStart = 1'b1;
        iLen   = 8'(len);
        iReady = ack;
        step();
        iStart = 1'b0;
        iReady = 1'b0;
    endtask

    task automatic feed(input logic b);
        iBitValid = 1'b1;
        iBit      = b;
        step();
        iBitValid = 1'b0;
        iBit      = 1'b0;
    endtask

    task automatic chk_result(input string name, input int ones, input int bip);
        chk({name, " valid"}, int'(oValid), 1);
        chk({name, " busy"}, int'(oBusy), 0);
        chk({name, " ones"}, int'(oOnes), ones);
        chk({name, " bipolar"}, $signed(oBipolar), bip);
    endtask

    task automatic ack();
        iReady = 1'b1;
        step();
        iReady = 1'b0;
        chk("ack valid", int'(oValid), 0);
        chk("ack busy", int'(oBusy), 0);
    endtask

    initial begin
        vecs[0] = '{len: 255, bits: '1, gaps: 1'b0, exp_ones: 255, exp_bip: 255};
        vecs[1] = '{len: 255, bits: '0, gaps: 1'b0, exp_ones: 0, exp_bip: -255};
        vecs[2] = '{len: 4, bits: 256'b1101, gaps: 1'b1, exp_ones: 3, exp_bip: 2};
        vecs[3] = '{len: 7, bits: 256'b0101010, gaps: 1'b0, exp_ones: 3, exp_bip: -1};
        vecs[4] = '{len: 1, bits: 256'b1, gaps: 1'b1, exp_ones: 1, exp_bip: 1};
        vecs[5] = '{len: 0, bits: '0, gaps: 1'b0, exp_ones: 0, exp_bip: 0};

        rst_n = 1'b0; iStart = 1'b0; iLen = '0; iBit = 1'b0; iBitValid = 1'b0; iReady = 1'b0;
        #12;
        chk("reset busy", int'(oBusy), 0);
        chk("reset valid", int'(oValid), 0);
        chk("reset ones", int'(oOnes), 0);
        chk("reset bipolar", $signed(oBipolar), 0);
        chk("reset overrun", int'(oOverrun), 0);
        rst_n = 1'b1;
        step();

        // Bits offered in IDLE must not start anything.
        for (int k = 0; k < 3; k++) begin
            feed(1'b1);
            chk("idle busy", int'(oBusy), 0);
            chk("idle valid", int'(oValid), 0);
        end

        for (int v = 0; v < 6; v++) begin
            start_win(vecs[v].len, 1'b0);
            for (int k = 0; k < vecs[v].len; k++) begin
                chk("run busy", int'(oBusy), 1);
                chk("run valid", int'(oValid), 0);
                if (vecs[v].gaps) begin
                    iBit = 1'b1;
                    step();
                    iBit = 1'b0;
                    chk("gap busy", int'(oBusy), 1);
                    chk("gap valid", int'(oValid), 0);
                end
                feed(vecs[v].bits[k]);
            end
            chk_result($sformatf("vec%0d", v), vecs[v].exp_ones, vecs[v].exp_bip);
            chk("vec overrun", int'(oOverrun), 0);
            if (vecs[v].len == 0) begin
                // Result must stay put while the consumer stalls.
                for (int c = 0; c < 10; c++) begin
                    step();
                    chk_result("hold", 0, 0);
                end
            end
            ack();
            chk("held ones", int'(oOnes), vecs[v].exp_ones);
            chk("held bipolar", $signed(oBipolar), vecs[v].exp_bip);
        end

        // Discarded result sets sticky overrun.
        start_win(2, 1'b0);
        feed(1'b1);
        feed(1'b1);
        chk_result("pre-overrun", 2, 2);
        start_win(3, 1'b0);
        chk("overrun valid", int'(oValid), 0);
        chk("overrun busy", int'(oBusy), 1);
        chk("overrun set", int'(oOverrun), 1);
        for (int k = 0; k < 3; k++) feed(1'b0);
        chk_result("post-overrun", 0, -3);
        chk("overrun sticky", int'(oOverrun), 1);
        ack();
        start_win(1, 1'b0);
        feed(1'b1);
        ack();
        chk("overrun sticky2", int'(oOverrun), 1);

        rst_n = 1'b0;
        #2;
        rst_n = 1'b1;
        step();
        chk("overrun cleared", int'(oOverrun), 0);

        // Start together with ready consumes the result cleanly.
        start_win(1, 1'b0);
        feed(1'b1);
        chk_result("pre-consume", 1, 1);
        start_win(1, 1'b1);
        chk("consume overrun", int'(oOverrun), 0);
        chk("consume busy", int'(oBusy), 1);
        feed(1'b0);
        chk_result("post-consume", 0, -1);
        ack();

        // Abort in RUN after 100 bits.
        start_win(255, 1'b0);
        for (int k = 0; k < 100; k++) feed(1'b1);
        chk("abort busy before", int'(oBusy), 1);
        start_win(5, 1'b0);
        chk("abort busy", int'(oBusy), 1);
        chk("abort overrun", int'(oOverrun), 0);
        feed(1'b1); feed(1'b1); feed(1'b0); feed(1'b0);
        chk("abort not done", int'(oValid), 0);
        feed(1'b0);
        chk_result("abort", 2, -1);
        chk("abort overrun2", int'(oOverrun), 0);
        ack();

        // Asynchronous reset mid-window with a nonzero held result.
        start_win(10, 1'b0);
        feed(1'b1); feed(1'b1); feed(1'b1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async busy", int'(oBusy), 0);
        chk("async valid", int'(oValid), 0);
        chk("async ones", int'(oOnes), 0);
        chk("async bipolar", $signed(oBipolar), 0);
        chk("async overrun", int'(oOverrun), 0);
        #3;
        rst_n = 1'b1;
        step();
        for (int k = 0; k < 12; k++) begin
            feed(1'b1);
            chk("post-reset busy", int'(oBusy), 0);
            chk("post-reset valid", int'(oValid), 0);
        end
        start_win(2, 1'b0);
        feed(1'b1);
        feed(1'b1);
        chk_result("post-reset window", 2, 2);
        ack();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
